uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and APB master that shares the UART transmitter between two byte-stream requesters.
- After reset it configures the UART register block once.
- For each granted byte it polls U_STAT.TBUSY, writes U_TXDATA, then pulses U_CTRL.STRTX with a set/clear write pair.
- It sits between the CPU-side print/debug sources and the UART register block's APB slave port.

---
 rtl/uart_tx_arbiter_if.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester, configuration and APB master signals of uart_tx_arbiter.
// master is the arbiter's view; slave is the view of the sources and the UART register block.
interface uart_tx_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req0_valid;
  logic                req1_valid;
  logic [7:0]          req0_data;
  logic [7:0]          req1_data;
  logic                req0_ready;
  logic                req1_ready;
  logic [3:0]          cfg_br;
  logic [7:0]          cfg_clk;
  logic                busy;
  logic                err;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    input  req0_valid, req1_valid, req0_data, req1_data, cfg_br, cfg_clk,
    input  prdata, pready, pslverr,
    output req0_ready, req1_ready, busy, err,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req0_valid, req1_valid, req0_data, req1_data, cfg_br, cfg_clk,
    output prdata, pready, pslverr,
    input  req0_ready, req1_ready, busy, err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmitter between two byte sources, driving its APB port.
// Define UART_TX_ARB_TIMEOUT_EN to drop a byte (and pulse err) after TIMEOUT_POLLS busy STAT reads.
module uart_tx_arbiter #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                TIMEOUT_POLLS = 1024
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_STAT_RD, S_DATA_WR, S_START_WR, S_CLR_WR
  } state_t;

  typedef enum logic [1:0] {PH_NONE, PH_SETUP, PH_ACCESS} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        lastGrant_q, lastGrant_d;
  logic [7:0]  byte_q, byte_d;
  logic [11:0] cfgHold_q, cfgHold_d;
  logic        err_q, err_d;
  logic        grant0, grant1, xferDone, tbusy, timeoutHit;
  logic [11:0] ctrlCfg;
  logic        unusedApb;

  // lastGrant_q=1 means req1 was served last, so req0 wins the next tie.
  assign grant0   = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || lastGrant_q);
  assign grant1   = (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid || !lastGrant_q);
  assign xferDone = (phase_q == PH_ACCESS) && bus.pready;
  assign tbusy    = bus.prdata[0];
  assign unusedApb = ^{bus.pslverr, bus.prdata[DATA_W-1:1]};

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_POLLS + 1);
  logic [CNT_W-1:0] pollCnt_q;

  assign timeoutHit = (pollCnt_q == CNT_W'(TIMEOUT_POLLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pollCnt_q <= '0;
    end else if (grant0 || grant1) begin
      pollCnt_q <= '0;
    end else if ((state_q == S_STAT_RD) && xferDone && tbusy) begin
      pollCnt_q <= pollCnt_q + CNT_W'(1);
    end
  end
`else
  localparam int unusedTimeout = TIMEOUT_POLLS;
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      phase_q     <= PH_NONE;
      lastGrant_q <= 1'b1;
      byte_q      <= '0;
      cfgHold_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lastGrant_q <= lastGrant_d;
      byte_q      <= byte_d;
      cfgHold_q   <= cfgHold_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lastGrant_d = lastGrant_q;
    byte_d      = byte_q;
    cfgHold_d   = cfgHold_q;
    err_d       = 1'b0;
    case (phase_q)
      PH_SETUP: begin
        phase_d   = PH_ACCESS;
        cfgHold_d = {bus.cfg_clk, bus.cfg_br};
      end
      PH_ACCESS: begin
        if (bus.pready) begin
          phase_d = PH_SETUP;
          case (state_q)
            S_STAT_RD: begin
              if (!tbusy) begin
                state_d = S_DATA_WR;
              end else if (timeoutHit) begin
                state_d = S_IDLE;
                phase_d = PH_NONE;
                err_d   = 1'b1;
              end
            end
            S_DATA_WR:  state_d = S_START_WR;
            S_START_WR: state_d = S_CLR_WR;
            default: begin
              state_d = S_IDLE;
              phase_d = PH_NONE;
            end
          endcase
        end
      end
      default: begin
        // INIT leaves reset with no transfer pending; IDLE waits for a grant.
        if (state_q == S_INIT) begin
          phase_d = PH_SETUP;
        end else if (grant0 || grant1) begin
          state_d     = S_STAT_RD;
          phase_d     = PH_SETUP;
          lastGrant_d = grant1;
          byte_d      = grant0 ? bus.req0_data : bus.req1_data;
        end
      end
    endcase
  end

  always_comb begin
    bus.psel    = (phase_q != PH_NONE);
    bus.penable = (phase_q == PH_ACCESS);
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    // CTRL config is live during SETUP and held from it during ACCESS.
    ctrlCfg = (phase_q == PH_SETUP) ? {bus.cfg_clk, bus.cfg_br} : cfgHold_q;
    if (phase_q != PH_NONE) begin
      case (state_q)
        S_STAT_RD: begin
          bus.paddr = BASE_ADDR + ADDR_W'(4);
        end
        S_DATA_WR: begin
          bus.pwrite = 1'b1;
          bus.paddr  = BASE_ADDR + ADDR_W'(8);
          bus.pwdata = DATA_W'({24'h0, byte_q});
          bus.pstrb  = STRB_W'(4'b0001);
        end
        S_START_WR: begin
          bus.pwrite = 1'b1;
          bus.paddr  = BASE_ADDR;
          bus.pwdata = DATA_W'({16'h0, ctrlCfg, 2'b00, 1'b1, 1'b1});
          bus.pstrb  = STRB_W'(4'b0011);
        end
        default: begin
          bus.pwrite = 1'b1;
          bus.paddr  = BASE_ADDR;
          bus.pwdata = DATA_W'({16'h0, ctrlCfg, 2'b00, 1'b0, 1'b1});
          bus.pstrb  = STRB_W'(4'b0011);
        end
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed bytes, a polling APB slave model and a monitor.
// Building with UART_TX_ARB_TIMEOUT_EN defined exercises the poll-timeout drop instead of endless polling.
module tb_uart_tx_arbiter;
  localparam logic [31:0] BASE = 32'h4000_1000;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } apbExp_t;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  uart_tx_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .TIMEOUT_POLLS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  apbExp_t     expQ[$];
  bit          expGrantQ[$];
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  apbExp_t     monExp;
  int          compareCount = 0;
  int          failCount = 0;
  int          expErr = 0;
  int          statBusyLeft = 0;
  int          cycle = 0;
  bit          readWaited = 0;
  logic [31:0] snapAddr = '0;
  logic [31:0] snapData = '0;
  logic        acc0, acc1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic checkBit(string name, logic actual, logic expected);
    checkOutput(name, {31'h0, actual}, {31'h0, expected});
  endtask

  task automatic logFail(string name, string what);
    compareCount++;
    failCount++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  function automatic logic [31:0] ctrlWord(logic strtx);
    return {16'h0, bus.cfg_clk, bus.cfg_br, 2'b00, strtx, 1'b1};
  endfunction

  task automatic pushXfer(logic wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    apbExp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    e.strb = strb;
    expQ.push_back(e);
  endtask

  // mode 0: full byte; 1: dropped after busyReads polls; 2: cut by reset during START_WR
  task automatic applyStimulus(int port, logic [7:0] data, int busyReads, int mode);
    int reads = (mode == 1) ? busyReads : busyReads + 1;
    for (int i = 0; i < reads; i++) pushXfer(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    if (mode == 1) begin
      expErr++;
    end else begin
      pushXfer(1'b1, BASE + 32'h8, {24'h0, data}, 4'b0001);
      if (mode == 0) begin
        pushXfer(1'b1, BASE, ctrlWord(1'b1), 4'b0011);
        pushXfer(1'b1, BASE, ctrlWord(1'b0), 4'b0011);
      end
    end
    expGrantQ.push_back(port == 1);
    if (port == 0) q0.push_back(data);
    else q1.push_back(data);
  endtask

  task automatic checkResetValues(string name);
    checkOutput({name, "Ctl"},
                {21'h0, bus.psel, bus.penable, bus.pwrite, bus.pstrb,
                 bus.req0_ready, bus.req1_ready, bus.err, bus.busy}, 32'h1);
    checkOutput({name, "Addr"}, bus.paddr, 32'h0);
    checkOutput({name, "Wdata"}, bus.pwdata, 32'h0);
  endtask

  task automatic waitIdle(string name, int maxCycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || q0.size() != 0 || q1.size() != 0 || expQ.size() != 0 ||
                expGrantQ.size() != 0) && n < maxCycles);
    if (n >= maxCycles)
      logFail(name, $sformatf("not idle after %0d cycles, %0d transfers outstanding", n, expQ.size()));
  endtask

  // Requesters: each presents the head of its byte queue and advances on acceptance.
  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      bus.req0_valid = (q0.size() != 0);
      bus.req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
      bus.req1_valid = (q1.size() != 0);
      bus.req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    end
  end

  // UART register block: writes complete at once, reads take one wait state.
  initial begin
    bus.pready  = 1'b1;
    bus.prdata  = 32'h0;
    bus.pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.psel && bus.penable && !bus.pwrite) begin
        if (!readWaited) begin
          bus.pready = 1'b0;
          readWaited = 1'b1;
        end else begin
          bus.pready = 1'b1;
          bus.prdata = {31'h2AAA_AAAA, statBusyLeft > 0};
          if (statBusyLeft > 0) statBusyLeft--;
        end
      end else begin
        bus.pready = 1'b1;
        readWaited = 1'b0;
      end
    end
  end

  // Monitor: grants, err pulses and completed APB transfers against the scoreboard.
  always @(negedge clk) begin
    if (bus.req0_ready || bus.req1_ready) begin
      checkBit("singleReady", bus.req0_ready & bus.req1_ready, 1'b0);
      if (expGrantQ.size() == 0) logFail("unexpectedGrant", "ready pulsed with no byte queued");
      else checkBit("grantPort", bus.req1_ready, expGrantQ.pop_front());
    end
    if (bus.err) begin
      checkBit("errExpected", expErr > 0, 1'b1);
      if (expErr > 0) expErr--;
    end
    if (bus.psel && !bus.penable) begin
      snapAddr = bus.paddr;
      snapData = bus.pwdata;
    end
    if (bus.psel && bus.penable) begin
      checkOutput("holdAddr", bus.paddr, snapAddr);
      checkOutput("holdData", bus.pwdata, snapData);
      if (bus.pready) begin
        if (expQ.size() == 0) begin
          logFail("unexpectedXfer", $sformatf("addr 0x%h with nothing expected", bus.paddr));
        end else begin
          monExp = expQ.pop_front();
          checkBit("xferWrite", bus.pwrite, monExp.wr);
          checkOutput("xferAddr", bus.paddr, monExp.addr);
          checkOutput("xferStrb", {28'h0, bus.pstrb}, {28'h0, monExp.strb});
          if (monExp.wr) checkOutput("xferData", bus.pwdata, monExp.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", failCount, compareCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t0;
    rst         = 1'b1;
    bus.cfg_br  = 4'h5;
    bus.cfg_clk = 8'h3C;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    checkOutput("initWord", ctrlWord(1'b0), 32'h0000_3C51);
    pushXfer(1'b1, BASE, ctrlWord(1'b0), 4'b0011);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkBit("initPending", bus.busy, 1'b1);
    @(negedge clk);
    checkOutput("initSetup", {30'h0, bus.psel, bus.penable}, 32'h2);
    repeat (2) @(negedge clk);
    checkBit("initDoneBusy", bus.busy, 1'b0);

    // Both sources valid: req0 wins the first tie, then strict alternation.
    applyStimulus(0, 8'hA0, 0, 0);
    applyStimulus(1, 8'hB0, 0, 0);
    applyStimulus(0, 8'hA1, 0, 0);
    applyStimulus(1, 8'hB1, 0, 0);
    waitIdle("alternate", 120);

    applyStimulus(0, 8'h41, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req0_ready || bus.req1_ready) && n < 20);
    t0 = cycle;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 60);
    checkOutput("latency", 32'(cycle - t0), 32'd10);
    waitIdle("single", 40);

    // New config between bytes, five busy polls while req0 waits its turn.
    bus.cfg_br   = 4'h9;
    bus.cfg_clk  = 8'hD2;
    statBusyLeft = 5;
    applyStimulus(1, 8'hC3, 5, 0);
    applyStimulus(0, 8'h3E, 0, 0);
    waitIdle("busyPoll", 150);

`ifdef UART_TX_ARB_TIMEOUT_EN
    statBusyLeft = 4;
    applyStimulus(1, 8'hEE, 4, 1);
`else
    statBusyLeft = 8;
    applyStimulus(1, 8'hEE, 8, 0);
`endif
    applyStimulus(0, 8'h77, 0, 0);
    waitIdle("timeout", 200);

    // Reset in the START_WR access phase, then INIT must precede the next grant.
    bus.cfg_br  = 4'hA;
    bus.cfg_clk = 8'h81;
    applyStimulus(0, 8'h99, 0, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.psel && !bus.penable && bus.pwrite && bus.paddr == BASE && bus.pwdata[1])
               && n < 50);
    if (n >= 50) logFail("startWr", "START_WR setup never seen");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkResetValues("midReset");
    pushXfer(1'b1, BASE, ctrlWord(1'b0), 4'b0011);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 8'h5A, 0, 0);
    waitIdle("afterReset", 100);
    checkOutput("errPending", 32'(expErr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
